// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Brief    : Multi-cycle RV32I control FSM driving the shared ALU/memory/regfile
//            datapath. Optional JAL support is enabled by defining MC_JAL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] OpCode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       Fault,
    output logic [3:0] State
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_BEQ   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_wait_cnt;
    logic            w_timeout;

    // Final waiting cycle: this one would bring the count up to TIMEOUT_CYCLES.
    assign w_timeout = (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= '0;
            case (r_state)
                S_FETCH, S_MEMREAD, S_MEMWRITE: begin
                    if (MemReady) begin
                        case (r_state)
                            S_FETCH:   r_state <= S_DECODE;
                            S_MEMREAD: r_state <= S_MEMWB;
                            default:   r_state <= S_FETCH;
                        endcase
                    end else if (w_timeout) begin
                        r_state <= S_TRAP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    case (OpCode)
                        c_OP_LOAD, c_OP_STORE: r_state <= S_MEMADR;
                        c_OP_R:                r_state <= S_EXECR;
                        c_OP_I:                r_state <= S_EXECI;
                        c_OP_BEQ:              r_state <= S_BEQ;
`ifdef MC_JAL_EN
                        c_OP_JAL:              r_state <= S_JAL;
`endif
                        default:               r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR:  r_state <= (OpCode == c_OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_EXECR,
                S_EXECI:   r_state <= S_ALUWB;
`ifdef MC_JAL_EN
                S_JAL:     r_state <= S_ALUWB;
`endif
                S_TRAP:    r_state <= S_TRAP;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    // Moore decode; rst masks everything so nothing is driven during reset.
    always_comb begin
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        ImmSrc    = 2'b00;
        Fault     = 1'b0;
        if (!rst) begin
            case (OpCode)
                c_OP_STORE: ImmSrc = 2'b01;
                c_OP_BEQ:   ImmSrc = 2'b10;
`ifdef MC_JAL_EN
                c_OP_JAL:   ImmSrc = 2'b11;
`endif
                default:    ImmSrc = 2'b00;
            endcase
            case (r_state)
                S_FETCH: begin
                    MemReq = 1'b1;
                    if (MemReady) begin
                        IRWrite   = 1'b1;
                        PCWrite   = 1'b1;
                        ALUSrcB   = 2'b10;
                        ResultSrc = 2'b10;
                    end
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD: begin
                    MemReq = 1'b1;
                    AdrSrc = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    MemReq   = 1'b1;
                    MemWrite = 1'b1;
                    AdrSrc   = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b10;
                end
                S_EXECI: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ALUOp   = 2'b10;
                end
                S_ALUWB:  RegWrite = 1'b1;
                S_BEQ: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b01;
                    PCWrite = Zero;
                end
`ifdef MC_JAL_EN
                S_JAL: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    PCWrite = 1'b1;
                end
`endif
                S_TRAP:   Fault = 1'b1;
                default: ;
            endcase
        end
    end

    assign State = r_state;

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle control FSM for the RV32I core. It sequences the shared datapath (one ALU, one unified instruction/data memory port, register file) over several cycles per instruction. It replaces the single-cycle main/ALU decoder pairing for the multi-cycle build. Inputs are the opcode and ALU Zero flag from the datapath, plus a ready handshake from memory. Outputs are per-cycle mux selects and write enables.

Parameters:
TIMEOUT_CYCLES, 255, max consecutive cycles a memory state waits with MemReady low before the FSM enters TRAP (must be >= 1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
OpCode  input  7  instr[6:0] from instruction register
Zero  input  1  ALU zero flag
MemReady  input  1  memory completes current access this cycle
MemReq  output  1  memory access request
MemWrite  output  1  write strobe, qualified by MemReq
AdrSrc  output  1  0 = PC, 1 = ALUOut as memory address
IRWrite  output  1  load instruction register and OldPC
PCWrite  output  1  load PC
RegWrite  output  1  register file write enable
ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1 register
ALUSrcB  output  2  00 rs2 register, 01 ImmExt, 10 constant 4
ALUOp  output  2  00 add, 01 sub/compare, 10 funct-decoded
ImmSrc  output  2  00 I, 01 S, 10 B, 11 J (combinational from OpCode)
Fault  output  1  sticky memory-timeout indication
State  output  4  current state encoding, for debug

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high.
- While rst is high: State = FETCH, wait counter = 0, Fault = 0, all enables and selects = 0.
- Outputs are Moore-decoded from State, except IRWrite/PCWrite in FETCH (qualified by MemReady) and PCWrite in BEQ (qualified by Zero). Any output not listed for a state is 0.
- State encodings and behaviour:
  - FETCH(0): MemReq=1, AdrSrc=0. On MemReady=1: IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, next state DECODE. Otherwise hold.
  - DECODE(1): ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target into ALUOut). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL (only with feature)
    - anything else -> FETCH (no architectural write)
  - MEMADR(2): ALUSrcA=10, ALUSrcB=01, ALUOp=00. Loads -> MEMREAD, stores -> MEMWRITE.
  - MEMREAD(3): MemReq=1, AdrSrc=1. On MemReady -> MEMWB.
  - MEMWB(4): ResultSrc=01, RegWrite=1. Next FETCH.
  - MEMWRITE(5): MemReq=1, MemWrite=1, AdrSrc=1, held stable until MemReady. Then FETCH.
  - EXECR(6): ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next ALUWB.
  - EXECI(7): ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next ALUWB.
  - ALUWB(8): ResultSrc=00, RegWrite=1. Next FETCH.
  - BEQ(9): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero. Next FETCH.
  - JAL(10): ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Next ALUWB (writes PC+4 to rd).
  - TRAP(11): Fault=1, all enables 0, absorbing until rst.
- Instruction latency: R/I 4 cycles, lw 5, sw 4, beq 3, jal 4 (zero-wait memory).
- Wait counter: counts cycles in FETCH/MEMREAD/MEMWRITE with MemReady=0 and clears on any state change.
  - When the counter reaches TIMEOUT_CYCLES with MemReady still 0, next state is TRAP.
  - MemReady=1 on that same cycle wins: normal transition, no trap.
- MemReady is ignored in all states other than FETCH/MEMREAD/MEMWRITE.
- rst asserted mid-instruction: immediate return to FETCH. No partial write completes after the reset edge.

Optional Feature:
MC_JAL_EN
- Defined: opcode 1101111 decodes to JAL state as above; ImmSrc=11 for that opcode.
- Undefined: JAL state and encoding 10 are unreachable; 1101111 is treated as unsupported (DECODE -> FETCH); ImmSrc=00.

Test Plan:
- Reset mid-MEMWRITE: assert rst with MemReady=0 -> same cycle MemReq=0, MemWrite=0; after release State=0, Fault=0.
- add (OpCode 0110011), MemReady tied 1 -> states 0,1,6,8,0. RegWrite=1 exactly one cycle (state 8), ALUOp=10 in state 6.
- lw with MemReady delayed 3 cycles in MEMREAD -> MEMREAD held 4 cycles, AdrSrc=1 throughout, then MEMWB with ResultSrc=01, RegWrite=1.
- beq twice, Zero=1 then Zero=0 -> PCWrite=1 in state 9 only for the first; Branch path never asserts RegWrite.
- TIMEOUT_CYCLES=4, MemReady held 0 in FETCH -> TRAP after 4 waiting cycles, Fault=1 sticky, MemReq=0. Repeat with MemReady=1 on cycle 4 -> DECODE, no trap.
- OpCode 1101111 -> with MC_JAL_EN: states 0,1,10,8 and PCWrite=1 in 10; without: states 0,1,0 with no RegWrite.
